// File: rtl/aes_pkg.sv
// Shared AES-128 decryptor definitions: FSM encoding, GF(2^8) arithmetic,
// forward/inverse S-box, rcon and the forward/inverse key-schedule steps.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_INIT  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? sh : 8'h00);
            sh  = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, which the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] g;
        g = gf_inv(x);
        return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = rk[31:0] ^ rk[63:32];
        p2 = rk[63:32] ^ rk[95:64];
        p1 = rk[95:64] ^ rk[127:96];
        p0 = rk[127:96] ^ sub_rot_word(p3) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// when mix_en is set, InvMixColumns. Byte 0 of the block sits in bits [127:120].
module aes_inv_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         mix_en,
    output logic [127:0] state_out
);

    logic [127:0] shifted_s;
    logic [127:0] subbed_s;
    logic [127:0] added_s;
    logic [127:0] mixed_s;

    // Row r of column c takes the byte from column (c - r) mod 4
    always_comb begin
        shifted_s = 128'd0;
        subbed_s  = 128'd0;
        mixed_s   = 128'd0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted_s[127 - 8*(4*c + r) -: 8] = state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            subbed_s[127 - 8*i -: 8] = inv_sbox(shifted_s[127 - 8*i -: 8]);
        end
        added_s = subbed_s ^ round_key;
        for (int c = 0; c < 4; c++) begin
            mixed_s[127 - 32*c -: 32] = inv_mix_column(added_s[127 - 32*c -: 32]);
        end
        if (mix_en) begin
            state_out = mixed_s;
        end else begin
            state_out = added_s;
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: forward key expansion (skipped on a key-cache hit),
// then one inverse round per cycle with the round key walked backwards on the fly.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_CACHE = 1,
    parameter int NR        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext,
    output logic         busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_state_e   state_r;
    logic [3:0]   rnd_r;
    logic [127:0] blk_r;
    logic [127:0] key_r;

    logic         accept_s;
    logic         kexp_last_s;
    logic         cache_hit_s;
    logic [127:0] cached_rk_s;
    logic [127:0] key_fwd_s;
    logic [127:0] key_inv_s;
    logic [127:0] round_out_s;
    logic         mix_en_s;

    assign in_ready    = !rst && (state_r == ST_IDLE);
    assign accept_s    = in_valid && in_ready;
    assign kexp_last_s = (state_r == ST_KEXP) && (rnd_r == LAST_RND);
    assign key_fwd_s   = key_fwd_step(key_r, rcon(rnd_r));
    assign key_inv_s   = key_inv_step(key_r, rcon(rnd_r));
    assign mix_en_s    = (state_r == ST_ROUND);

    aes_inv_round_comb u_round (
        .state_in  (blk_r),
        .round_key (key_r),
        .mix_en    (mix_en_s),
        .state_out (round_out_s)
    );

    generate
        if (KEY_CACHE != 0) begin : g_cache
            logic [127:0] cache_key_r;
            logic [127:0] cache_rk_r;
            logic         cache_valid_r;

            // A miss claims the cache for the new key; it becomes valid once rk10 exists
            always_ff @(posedge clk) begin
                if (rst) begin
                    cache_valid_r <= 1'b0;
                    cache_key_r   <= 128'd0;
                    cache_rk_r    <= 128'd0;
                end else if (accept_s && !cache_hit_s) begin
                    cache_valid_r <= 1'b0;
                    cache_key_r   <= key;
                end else if (kexp_last_s) begin
                    cache_valid_r <= 1'b1;
                    cache_rk_r    <= key_fwd_s;
                end
            end

            assign cache_hit_s = cache_valid_r && (key == cache_key_r);
            assign cached_rk_s = cache_rk_r;
        end else begin : g_no_cache
            assign cache_hit_s = 1'b0;
            assign cached_rk_s = 128'd0;
        end
    endgenerate

    // Control FSM with the data/key registers and the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rnd_r     <= 4'd0;
            blk_r     <= 128'd0;
            key_r     <= 128'd0;
            out_valid <= 1'b0;
            plaintext <= 128'd0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        blk_r <= ciphertext;
                        busy  <= 1'b1;
                        if (cache_hit_s) begin
                            key_r   <= cached_rk_s;
                            rnd_r   <= LAST_RND;
                            state_r <= ST_INIT;
                        end else begin
                            key_r   <= key;
                            rnd_r   <= 4'd1;
                            state_r <= ST_KEXP;
                        end
                    end
                end
                ST_KEXP: begin
                    key_r <= key_fwd_s;
                    if (rnd_r == LAST_RND) begin
                        state_r <= ST_INIT;
                    end else begin
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                ST_INIT: begin
                    blk_r   <= blk_r ^ key_r;
                    key_r   <= key_inv_s;
                    rnd_r   <= LAST_RND - 4'd1;
                    state_r <= ST_ROUND;
                end
                ST_ROUND: begin
                    blk_r <= round_out_s;
                    key_r <= key_inv_s;
                    if (rnd_r == 4'd1) begin
                        rnd_r   <= 4'd0;
                        state_r <= ST_FINAL;
                    end else begin
                        rnd_r <= rnd_r - 4'd1;
                    end
                end
                ST_FINAL: begin
                    plaintext <= round_out_s;
                    out_valid <= 1'b1;
                    rnd_r     <= 4'd0;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rnd_r     <= 4'd0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
